// File: rtl/dcache_port_ctrl.sv
// ---------------------------------------------------------------------------------------------
// dcache_port_ctrl
//   Per-request-port controller of the non-blocking, write-back, set-associative L1 data cache.
//   Accepts one load/store at a time from a core port, performs the tag lookup through the
//   shared SRAM arbiter, completes hits locally and hands misses, upgrades (store to a shared
//   line) and uncached accesses to the miss handler. Collisions with an outstanding MSHR stall
//   the port until the conflicting miss retires.
//
// Optional build macro: DCACHE_PORT_PERF_EN adds hit_cnt_o / miss_cnt_o (32-bit, wrapping).
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   bypass_i, busy_o        cache disable; controller not idle
//   req_i .. size_i         core request (index in request cycle, tag one cycle later)
//   gnt_o, rvalid_o, rdata_o core response
//   sram_*                  tag/data SRAM arbiter interface (read data one cycle after grant)
//   hit_way_i, shared_way_i per-way hit and shared-line flags from the tag comparators
//   miss_*                  miss / uncached request to the miss handler
//   active_serving_i, critical_word_*  refill return path
//   bypass_gnt_i, bypass_valid_i, bypass_data_i  uncached handshake
//   mshr_*                  MSHR collision check
//   hit_cnt_o, miss_cnt_o   (DCACHE_PORT_PERF_EN only) lookup decision counters
// ---------------------------------------------------------------------------------------------
module dcache_port_ctrl #(
    parameter int unsigned SET_ASSOC   = 8,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned TAG_WIDTH   = 44,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned BYTE_OFFSET = 4,
    parameter logic [63:0] CACHE_BASE  = 64'h8000_0000,
    parameter logic [63:0] CACHE_SIZE  = 64'h4000_0000
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            bypass_i,
    output logic                            busy_o,
    input  logic                            req_i,
    input  logic [INDEX_WIDTH-1:0]          index_i,
    input  logic [TAG_WIDTH-1:0]            tag_i,
    input  logic                            tag_valid_i,
    input  logic                            kill_i,
    input  logic                            we_i,
    input  logic [63:0]                     wdata_i,
    input  logic [7:0]                      be_i,
    input  logic [1:0]                      size_i,
    output logic                            gnt_o,
    output logic                            rvalid_o,
    output logic [63:0]                     rdata_o,
    output logic [SET_ASSOC-1:0]            sram_req_o,
    output logic [INDEX_WIDTH-1:0]          sram_addr_o,
    input  logic                            sram_gnt_i,
    input  logic [SET_ASSOC*LINE_WIDTH-1:0] sram_rdata_i,
    output logic [TAG_WIDTH-1:0]            sram_tag_o,
    output logic                            sram_we_o,
    output logic [LINE_WIDTH-1:0]           sram_wdata_o,
    output logic [LINE_WIDTH/8-1:0]         sram_be_o,
    input  logic [SET_ASSOC-1:0]            hit_way_i,
    input  logic [SET_ASSOC-1:0]            shared_way_i,
    output logic                            miss_valid_o,
    output logic                            miss_bypass_o,
    output logic [63:0]                     miss_addr_o,
    output logic                            miss_we_o,
    output logic [63:0]                     miss_wdata_o,
    output logic [7:0]                      miss_be_o,
    output logic [1:0]                      miss_size_o,
    input  logic                            miss_gnt_i,
    input  logic                            active_serving_i,
    input  logic [63:0]                     critical_word_i,
    input  logic                            critical_word_valid_i,
    input  logic                            bypass_gnt_i,
    input  logic                            bypass_valid_i,
    input  logic [63:0]                     bypass_data_i,
    output logic [55:0]                     mshr_addr_o,
    input  logic                            mshr_addr_matches_i,
    input  logic                            mshr_index_matches_i
`ifdef DCACHE_PORT_PERF_EN
    ,
    output logic [31:0]                     hit_cnt_o,
    output logic [31:0]                     miss_cnt_o
`endif
);

    localparam int unsigned AddrWidth    = TAG_WIDTH + INDEX_WIDTH;
    localparam int unsigned WordSelWidth = BYTE_OFFSET - 3;
    localparam int unsigned BeWidth      = LINE_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTag,
        StStoreReq,
        StWaitMshr,
        StWaitRefillGnt,
        StWaitCriticalWord,
        StWaitBypassGnt,
        StWaitBypassValid
    } state_e;

    state_e state_q, state_d;

    // Saved request
    logic                   we_q, we_d;
    logic [63:0]            wdata_q, wdata_d;
    logic [7:0]             be_q, be_d;
    logic [1:0]             size_q, size_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [SET_ASSOC-1:0]   way_q, way_d;
    logic                   bypass_q, bypass_d;
    logic                   killed_q, killed_d;

    // Lookup decision terms
    logic                    tag_decide;
    logic                    uncached;
    logic                    hit;
    logic                    shared_hit;
    logic                    cached_hit;
    logic [63:0]             lookup_addr;
    logic [AddrWidth-1:0]    saved_addr;
    logic [WordSelWidth-1:0] word_sel;
    logic [LINE_WIDTH-1:0]   hit_line;
    logic [63:0]             hit_word;

    assign busy_o      = (state_q != StIdle);
    assign word_sel    = index_q[BYTE_OFFSET-1:3];
    assign saved_addr  = {tag_q, index_q};
    assign lookup_addr = 64'({tag_i, index_q});
    assign hit         = |hit_way_i;
    assign shared_hit  = |(hit_way_i & shared_way_i);
    // A store to a shared line needs ownership first, so it is handled as a miss (upgrade).
    assign cached_hit  = hit && !(we_q && shared_hit);
    // A kill on a pending load pre-empts the lookup decision.
    assign tag_decide  = (state_q == StWaitTag) && tag_valid_i && !(kill_i && !we_q);
    assign uncached    = bypass_i || (lookup_addr < CACHE_BASE) ||
                         (lookup_addr >= (CACHE_BASE + CACHE_SIZE));

    // One-hot way select of the line read in the lookup cycle.
    always_comb begin
        hit_line = '0;
        for (int unsigned w = 0; w < SET_ASSOC; w++) begin
            if (hit_way_i[w]) begin
                hit_line = hit_line | sram_rdata_i[w*LINE_WIDTH +: LINE_WIDTH];
            end
        end
        hit_word = hit_line[word_sel*64 +: 64];
    end

    // State and saved request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            size_q   <= '0;
            index_q  <= '0;
            tag_q    <= '0;
            way_q    <= '0;
            bypass_q <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            size_q   <= size_d;
            index_q  <= index_d;
            tag_q    <= tag_d;
            way_q    <= way_d;
            bypass_q <= bypass_d;
            killed_q <= killed_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        size_d   = size_q;
        index_d  = index_q;
        tag_d    = tag_q;
        way_d    = way_q;
        bypass_d = bypass_q;
        killed_d = killed_q;

        // A load killed after leaving the lookup still finishes its handshake, silently.
        if (kill_i && !we_q && (state_q inside {StWaitMshr, StWaitRefillGnt, StWaitCriticalWord,
                                                StWaitBypassGnt, StWaitBypassValid})) begin
            killed_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (req_i && sram_gnt_i) begin
                    we_d     = we_i;
                    wdata_d  = wdata_i;
                    be_d     = be_i;
                    size_d   = size_i;
                    index_d  = index_i;
                    bypass_d = 1'b0;
                    killed_d = 1'b0;
                    state_d  = StWaitTag;
                end
            end
            StWaitTag: begin
                if (kill_i && !we_q) begin
                    state_d = StIdle;
                end else if (tag_valid_i) begin
                    tag_d = tag_i;
                    if (uncached) begin
                        bypass_d = 1'b1;
                        state_d  = StWaitMshr;
                    end else if (cached_hit && we_q) begin
                        way_d   = hit_way_i;
                        state_d = StStoreReq;
                    end else if (cached_hit) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StWaitMshr;
                    end
                end
            end
            StStoreReq: begin
                if (sram_gnt_i) state_d = StIdle;
            end
            StWaitMshr: begin
                if (!(mshr_index_matches_i || mshr_addr_matches_i)) begin
                    state_d = bypass_q ? StWaitBypassGnt : StWaitRefillGnt;
                end
            end
            StWaitRefillGnt: begin
                if (miss_gnt_i) state_d = we_q ? StIdle : StWaitCriticalWord;
            end
            StWaitCriticalWord: begin
                if (critical_word_valid_i && active_serving_i) state_d = StIdle;
            end
            StWaitBypassGnt: begin
                if (bypass_gnt_i) state_d = StWaitBypassValid;
            end
            StWaitBypassValid: begin
                if (bypass_valid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        gnt_o         = 1'b0;
        rvalid_o      = 1'b0;
        rdata_o       = '0;
        sram_req_o    = '0;
        sram_addr_o   = '0;
        sram_tag_o    = '0;
        sram_we_o     = 1'b0;
        sram_wdata_o  = '0;
        sram_be_o     = '0;
        miss_valid_o  = 1'b0;
        miss_bypass_o = 1'b0;
        miss_addr_o   = '0;
        miss_we_o     = 1'b0;
        miss_wdata_o  = '0;
        miss_be_o     = '0;
        miss_size_o   = '0;
        mshr_addr_o   = '0;

        case (state_q)
            StIdle: begin
                if (req_i) begin
                    sram_req_o  = '1;
                    sram_addr_o = index_i;
                    // Stores are only acknowledged once their outcome is known.
                    gnt_o       = sram_gnt_i && !we_i;
                end
            end
            StWaitTag: begin
                sram_addr_o = index_q;
                if (tag_valid_i) sram_tag_o = tag_i;
                if (tag_decide && !uncached && cached_hit && !we_q) begin
                    rvalid_o = 1'b1;
                    rdata_o  = hit_word;
                end
            end
            StStoreReq: begin
                sram_req_o   = way_q;
                sram_addr_o  = index_q;
                sram_tag_o   = tag_q;
                sram_we_o    = 1'b1;
                sram_wdata_o = {(LINE_WIDTH/64){wdata_q}};
                sram_be_o    = BeWidth'(be_q) << (word_sel * 8);
                gnt_o        = sram_gnt_i;
            end
            StWaitMshr: begin
                mshr_addr_o = 56'(saved_addr);
            end
            StWaitRefillGnt: begin
                miss_valid_o = 1'b1;
                miss_addr_o  = 64'({saved_addr[AddrWidth-1:BYTE_OFFSET], {BYTE_OFFSET{1'b0}}});
                miss_we_o    = we_q;
                miss_wdata_o = wdata_q;
                miss_be_o    = be_q;
                miss_size_o  = size_q;
                gnt_o        = miss_gnt_i && we_q;
            end
            StWaitCriticalWord: begin
                if (critical_word_valid_i && active_serving_i && !(killed_q || kill_i)) begin
                    rvalid_o = 1'b1;
                    rdata_o  = critical_word_i;
                end
            end
            StWaitBypassGnt: begin
                miss_valid_o  = 1'b1;
                miss_bypass_o = 1'b1;
                miss_addr_o   = 64'(saved_addr);
                miss_we_o     = we_q;
                miss_wdata_o  = wdata_q;
                miss_be_o     = be_q;
                miss_size_o   = size_q;
            end
            StWaitBypassValid: begin
                if (bypass_valid_i) begin
                    if (we_q) begin
                        gnt_o = 1'b1;
                    end else if (!(killed_q || kill_i)) begin
                        rvalid_o = 1'b1;
                        rdata_o  = bypass_data_i;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef DCACHE_PORT_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Only cacheable lookups count; uncached accesses are neither hits nor misses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (tag_decide && !uncached) begin
            if (cached_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            else            miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_port_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_dcache_port_ctrl
//   Directed testbench for dcache_port_ctrl: reset, load/store hits, upgrade, MSHR stall with
//   refill, uncached (bypass and out-of-range) accesses and kills.
// ---------------------------------------------------------------------------------------------
module tb_dcache_port_ctrl;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          bypass_i, busy_o, req_i, tag_valid_i, kill_i, we_i;
    logic [11:0]   index_i;
    logic [43:0]   tag_i;
    logic [63:0]   wdata_i;
    logic [7:0]    be_i;
    logic [1:0]    size_i;
    logic          gnt_o, rvalid_o;
    logic [63:0]   rdata_o;
    logic [7:0]    sram_req_o;
    logic [11:0]   sram_addr_o;
    logic          sram_gnt_i;
    logic [1023:0] sram_rdata_i;
    logic [43:0]   sram_tag_o;
    logic          sram_we_o;
    logic [127:0]  sram_wdata_o;
    logic [15:0]   sram_be_o;
    logic [7:0]    hit_way_i, shared_way_i;
    logic          miss_valid_o, miss_bypass_o, miss_we_o;
    logic [63:0]   miss_addr_o, miss_wdata_o;
    logic [7:0]    miss_be_o;
    logic [1:0]    miss_size_o;
    logic          miss_gnt_i, active_serving_i, critical_word_valid_i;
    logic [63:0]   critical_word_i;
    logic          bypass_gnt_i, bypass_valid_i;
    logic [63:0]   bypass_data_i;
    logic [55:0]   mshr_addr_o;
    logic          mshr_addr_matches_i, mshr_index_matches_i;
`ifdef DCACHE_PORT_PERF_EN
    logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_port_ctrl dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .bypass_i              (bypass_i),
        .busy_o                (busy_o),
        .req_i                 (req_i),
        .index_i               (index_i),
        .tag_i                 (tag_i),
        .tag_valid_i           (tag_valid_i),
        .kill_i                (kill_i),
        .we_i                  (we_i),
        .wdata_i               (wdata_i),
        .be_i                  (be_i),
        .size_i                (size_i),
        .gnt_o                 (gnt_o),
        .rvalid_o              (rvalid_o),
        .rdata_o               (rdata_o),
        .sram_req_o            (sram_req_o),
        .sram_addr_o           (sram_addr_o),
        .sram_gnt_i            (sram_gnt_i),
        .sram_rdata_i          (sram_rdata_i),
        .sram_tag_o            (sram_tag_o),
        .sram_we_o             (sram_we_o),
        .sram_wdata_o          (sram_wdata_o),
        .sram_be_o             (sram_be_o),
        .hit_way_i             (hit_way_i),
        .shared_way_i          (shared_way_i),
        .miss_valid_o          (miss_valid_o),
        .miss_bypass_o         (miss_bypass_o),
        .miss_addr_o           (miss_addr_o),
        .miss_we_o             (miss_we_o),
        .miss_wdata_o          (miss_wdata_o),
        .miss_be_o             (miss_be_o),
        .miss_size_o           (miss_size_o),
        .miss_gnt_i            (miss_gnt_i),
        .active_serving_i      (active_serving_i),
        .critical_word_i       (critical_word_i),
        .critical_word_valid_i (critical_word_valid_i),
        .bypass_gnt_i          (bypass_gnt_i),
        .bypass_valid_i        (bypass_valid_i),
        .bypass_data_i         (bypass_data_i),
        .mshr_addr_o           (mshr_addr_o),
        .mshr_addr_matches_i   (mshr_addr_matches_i),
        .mshr_index_matches_i  (mshr_index_matches_i)
`ifdef DCACHE_PORT_PERF_EN
        ,
        .hit_cnt_o             (hit_cnt_o),
        .miss_cnt_o            (miss_cnt_o)
`endif
    );

    // Drop every per-cycle handshake input; addresses and data are left as they are.
    task automatic clr();
        req_i = 0; tag_valid_i = 0; kill_i = 0; sram_gnt_i = 0; hit_way_i = 0; shared_way_i = 0;
        miss_gnt_i = 0; active_serving_i = 0; critical_word_valid_i = 0; bypass_gnt_i = 0;
        bypass_valid_i = 0; mshr_addr_matches_i = 0; mshr_index_matches_i = 0;
    endtask

    // Advance to just after the next rising edge with handshakes cleared.
    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
    endtask

    // Present a request that the SRAM arbiter grants immediately.
    task automatic issue(input logic we, input logic [11:0] idx, input logic [63:0] wd,
                         input logic [7:0] be, input logic [1:0] sz);
        cyc();
        req_i = 1; we_i = we; index_i = idx; wdata_i = wd; be_i = be; size_i = sz;
        sram_gnt_i = 1;
    endtask

    task automatic test_reset();
        clr();
        bypass_i = 0; we_i = 0; index_i = 0; tag_i = 0; wdata_i = 0; be_i = 0; size_i = 0;
        critical_word_i = 0; bypass_data_i = 0;
        sram_rdata_i = '0;
        sram_rdata_i[0*128 +: 64]      = 64'hA0;
        sram_rdata_i[0*128 + 64 +: 64] = 64'hA1;
        sram_rdata_i[1*128 +: 64]      = 64'h2222;
        sram_rdata_i[2*128 +: 64]      = 64'hDEAD_BEEF;
        sram_rdata_i[2*128 + 64 +: 64] = 64'h1111;
        #2;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %0b want 0", busy_o); end
        n_checks++; if ({gnt_o, rvalid_o, miss_valid_o, sram_we_o} !== 4'b0) begin n_fail++;
            $display("FAIL reset_outs: got %b want 0000", {gnt_o, rvalid_o, miss_valid_o, sram_we_o}); end
        n_checks++; if (sram_req_o !== 8'h00) begin n_fail++;
            $display("FAIL reset_sram_req: got %0h want 0", sram_req_o); end
        @(posedge clk); @(posedge clk);
        #1 rst_ni = 1;
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++;
            $display("FAIL post_reset_busy: got %0b want 0", busy_o); end
    endtask

    task automatic test_no_grant();
        cyc();
        req_i = 1; we_i = 0; index_i = 12'h040; sram_gnt_i = 0;
        #1;
        n_checks++; if (sram_req_o !== 8'hFF || sram_addr_o !== 12'h040) begin n_fail++;
            $display("FAIL nognt_sram: got req %0h addr %0h want ff 040", sram_req_o, sram_addr_o); end
        n_checks++; if (gnt_o !== 1'b0) begin n_fail++;
            $display("FAIL nognt_gnt: got %0b want 0", gnt_o); end
        cyc();
        n_checks++; if (busy_o !== 1'b0) begin n_fail++;
            $display("FAIL nognt_busy: got %0b want 0", busy_o); end
    endtask

    task automatic test_load_hit(input logic [11:0] idx, input logic [63:0] exp);
        issue(1'b0, idx, 64'h0, 8'h00, 2'd3);
        #1;
        n_checks++; if (gnt_o !== 1'b1 || sram_req_o !== 8'hFF) begin n_fail++;
            $display("FAIL ld_hit_gnt: got gnt %0b req %0h want 1 ff", gnt_o, sram_req_o); end
        cyc();
        tag_valid_i = 1; tag_i = 44'h80000; hit_way_i = 8'b0000_0100;
        #1;
        n_checks++; if (sram_tag_o !== 44'h80000 || busy_o !== 1'b1) begin n_fail++;
            $display("FAIL ld_hit_tag: got tag %0h busy %0b want 80000 1", sram_tag_o, busy_o); end
        n_checks++; if (rvalid_o !== 1'b1 || rdata_o !== exp) begin n_fail++;
            $display("FAIL ld_hit_data: got v %0b d %0h want 1 %0h", rvalid_o, rdata_o, exp); end
        cyc();
        n_checks++; if (busy_o !== 1'b0 || rvalid_o !== 1'b0) begin n_fail++;
            $display("FAIL ld_hit_done: got busy %0b rv %0b want 0 0", busy_o, rvalid_o); end
    endtask

    task automatic test_store_hit(input logic [11:0] idx, input logic [7:0] be,
                                  input logic [15:0] exp_be);
        issue(1'b1, idx, 64'h55, be, 2'd0);
        #1;
        n_checks++; if (gnt_o !== 1'b0) begin n_fail++;
            $display("FAIL st_hit_early_gnt: got %0b want 0", gnt_o); end
        cyc();
        tag_valid_i = 1; tag_i = 44'h80000; hit_way_i = 8'b0000_0010;
        #1;
        n_checks++; if (gnt_o !== 1'b0 || rvalid_o !== 1'b0) begin n_fail++;
            $display("FAIL st_hit_tag: got gnt %0b rv %0b want 0 0", gnt_o, rvalid_o); end
        cyc();
        #1;
        n_checks++; if (sram_we_o !== 1'b1 || sram_req_o !== 8'b0000_0010) begin n_fail++;
            $display("FAIL st_hit_write: got we %0b req %0h want 1 02", sram_we_o, sram_req_o); end
        n_checks++; if (sram_be_o !== exp_be) begin n_fail++;
            $display("FAIL st_hit_be: got %0h want %0h", sram_be_o, exp_be); end
        n_checks++; if (sram_wdata_o !== {64'h55, 64'h55}) begin n_fail++;
            $display("FAIL st_hit_wdata: got %0h want replicated 55", sram_wdata_o); end
        n_checks++; if (gnt_o !== 1'b0) begin n_fail++;
            $display("FAIL st_hit_gnt_wait: got %0b want 0", gnt_o); end
        cyc();
        sram_gnt_i = 1;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++;
            $display("FAIL st_hit_gnt: got %0b want 1", gnt_o); end
        cyc();
        n_checks++; if (busy_o !== 1'b0) begin n_fail++;
            $display("FAIL st_hit_done: got busy %0b want 0", busy_o); end
    endtask

    task automatic test_store_upgrade();
        issue(1'b1, 12'h080, 64'hABCD, 8'hFF, 2'd3);
        cyc();
        tag_valid_i = 1; tag_i = 44'h80001; hit_way_i = 8'b0000_1000; shared_way_i = 8'b0000_1000;
        cyc();
        #1;
        n_checks++; if (mshr_addr_o !== 56'h8000_1080 || miss_valid_o !== 1'b0) begin n_fail++;
            $display("FAIL upg_mshr: got addr %0h mv %0b want 80001080 0", mshr_addr_o, miss_valid_o); end
        cyc();
        #1;
        n_checks++; if (miss_valid_o !== 1'b1 || miss_bypass_o !== 1'b0 || miss_we_o !== 1'b1) begin
            n_fail++;
            $display("FAIL upg_miss: got v %0b b %0b we %0b want 1 0 1",
                     miss_valid_o, miss_bypass_o, miss_we_o); end
        n_checks++; if (miss_addr_o !== 64'h8000_1080 || miss_wdata_o !== 64'hABCD) begin n_fail++;
            $display("FAIL upg_addr: got %0h %0h want 80001080 abcd", miss_addr_o, miss_wdata_o); end
        n_checks++; if (gnt_o !== 1'b0) begin n_fail++;
            $display("FAIL upg_gnt_wait: got %0b want 0", gnt_o); end
        cyc();
        miss_gnt_i = 1;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++;
            $display("FAIL upg_gnt: got %0b want 1", gnt_o); end
        cyc();
        n_checks++; if (busy_o !== 1'b0) begin n_fail++;
            $display("FAIL upg_done: got busy %0b want 0", busy_o); end
    endtask

    // Load miss; optionally killed while waiting on the MSHR so the refill returns silently.
    task automatic test_load_miss(input logic kill_mid, input int stall_cycles);
        issue(1'b0, 12'h0C8, 64'h0, 8'hFF, 2'd3);
        cyc();
        tag_valid_i = 1; tag_i = 44'h80002; hit_way_i = 8'h00;
        for (int i = 0; i < stall_cycles; i++) begin
            cyc();
            mshr_index_matches_i = 1;
            if (i == 0) kill_i = kill_mid;
            #1;
            n_checks++; if (miss_valid_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++;
                $display("FAIL miss_stall_%0d: got mv %0b busy %0b want 0 1", i, miss_valid_o, busy_o); end
        end
        cyc();
        cyc();
        #1;
        n_checks++; if (miss_valid_o !== 1'b1 || miss_addr_o !== 64'h8000_20C0 || miss_we_o !== 1'b0)
        begin n_fail++;
            $display("FAIL miss_req: got v %0b a %0h we %0b want 1 800020c0 0",
                     miss_valid_o, miss_addr_o, miss_we_o); end
        miss_gnt_i = 1;
        cyc();
        critical_word_valid_i = 1; critical_word_i = 64'h1234;
        #1;
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++;
            $display("FAIL miss_not_serving: got rv %0b want 0", rvalid_o); end
        cyc();
        critical_word_valid_i = 1; active_serving_i = 1;
        #1;
        n_checks++; if (rvalid_o !== !kill_mid || (!kill_mid && rdata_o !== 64'h1234)) begin n_fail++;
            $display("FAIL miss_refill: got rv %0b d %0h want %0b 1234", rvalid_o, rdata_o, !kill_mid); end
        cyc();
        n_checks++; if (busy_o !== 1'b0) begin n_fail++;
            $display("FAIL miss_done: got busy %0b want 0", busy_o); end
    endtask

    task automatic test_bypass_load();
        bypass_i = 1;
        issue(1'b0, 12'h010, 64'h0, 8'hFF, 2'd3);
        cyc();
        tag_valid_i = 1; tag_i = 44'h80003; hit_way_i = 8'b0000_0001;
        #1;
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++;
            $display("FAIL byp_no_hit: got rv %0b want 0", rvalid_o); end
        cyc();
        cyc();
        bypass_gnt_i = 1;
        #1;
        n_checks++; if (miss_valid_o !== 1'b1 || miss_bypass_o !== 1'b1) begin n_fail++;
            $display("FAIL byp_req: got v %0b b %0b want 1 1", miss_valid_o, miss_bypass_o); end
        n_checks++; if (miss_addr_o !== 64'h8000_3010) begin n_fail++;
            $display("FAIL byp_addr: got %0h want 80003010", miss_addr_o); end
        cyc();
        #1;
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++;
            $display("FAIL byp_early: got rv %0b want 0", rvalid_o); end
        cyc();
        bypass_valid_i = 1; bypass_data_i = 64'hCAFE;
        #1;
        n_checks++; if (rvalid_o !== 1'b1 || rdata_o !== 64'hCAFE) begin n_fail++;
            $display("FAIL byp_data: got rv %0b d %0h want 1 cafe", rvalid_o, rdata_o); end
        cyc();
        bypass_i = 0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++;
            $display("FAIL byp_done: got busy %0b want 0", busy_o); end
    endtask

    // Cacheable-window edges: a hit on way 0 only returns data inside the window.
    task automatic test_range(input logic [43:0] tag, input logic [11:0] idx,
                              input logic cached, input logic [63:0] exp);
        issue(1'b0, idx, 64'h0, 8'hFF, 2'd3);
        cyc();
        tag_valid_i = 1; tag_i = tag; hit_way_i = 8'b0000_0001;
        #1;
        n_checks++; if (rvalid_o !== cached || (cached && rdata_o !== exp)) begin n_fail++;
            $display("FAIL range_%0h_%0h: got rv %0b d %0h want %0b %0h",
                     tag, idx, rvalid_o, rdata_o, cached, exp); end
        if (!cached) begin
            cyc();
            cyc();
            bypass_gnt_i = 1;
            #1;
            n_checks++; if (miss_bypass_o !== 1'b1 || miss_addr_o !== 64'({tag, idx})) begin
                n_fail++;
                $display("FAIL range_byp_%0h: got b %0b a %0h want 1 %0h",
                         tag, miss_bypass_o, miss_addr_o, 64'({tag, idx})); end
            cyc();
            bypass_valid_i = 1;
        end
        cyc();
        n_checks++; if (busy_o !== 1'b0) begin n_fail++;
            $display("FAIL range_done_%0h: got busy %0b want 0", tag, busy_o); end
    endtask

    task automatic test_kill_wait_tag();
        issue(1'b0, 12'h040, 64'h0, 8'hFF, 2'd3);
        cyc();
        kill_i = 1; tag_valid_i = 1; tag_i = 44'h80000; hit_way_i = 8'b0000_0100;
        #1;
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++;
            $display("FAIL kill_rvalid: got %0b want 0", rvalid_o); end
        cyc();
        n_checks++; if (busy_o !== 1'b0 || rvalid_o !== 1'b0) begin n_fail++;
            $display("FAIL kill_idle: got busy %0b rv %0b want 0 0", busy_o, rvalid_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_no_grant();
        test_load_hit(12'h040, 64'hDEAD_BEEF);
        test_load_hit(12'h048, 64'h1111);
        test_store_hit(12'h040, 8'h01, 16'h0001);
        test_store_hit(12'h048, 8'h0F, 16'h0F00);
        test_store_upgrade();
        test_load_miss(1'b0, 3);
        test_load_miss(1'b1, 1);
        test_bypass_load();
        test_range(44'h01000, 12'h040, 1'b0, 64'h0);
        test_range(44'h80000, 12'h000, 1'b1, 64'hA0);
        test_range(44'hBFFFF, 12'hFF8, 1'b1, 64'hA1);
        test_range(44'hC0000, 12'h000, 1'b0, 64'h0);
        test_kill_wait_tag();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
